// File: rtl/bram_stream_reader.sv
// Read sequencer for a single-port block RAM: walks a wrap-around address range
// and streams the words out on valid/ready through a 2-entry skid buffer.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic [ADDR_WIDTH:0]   ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int AW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_r, state_next_s;
  logic [AW-1:0]         addr_r;
  logic [AW-1:0]         hold_r;
  logic [AW-1:0]         rem_r;
  logic                  inflight_r;
  logic                  inflight_last_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] fifo_dat_r [2];
  logic                  fifo_last_r [2];
  logic                  rd_ptr_r;
  logic                  wr_ptr_r;
  logic [1:0]            count_r;

  logic                  pop_s;
  logic                  push_s;
  logic                  issue_s;
  logic                  accept_s;
  logic                  done_next_s;
  logic                  head_last_s;
  logic [2:0]            occ_s;
  logic [2:0]            lim_s;
  logic [AW-1:0]         ram_addr_s;
  logic [AW-1:0]         addr_inc_s;

  assign ram_we   = 1'b0;
  assign ram_di   = {DATA_WIDTH{1'b0}};
  assign ram_addr = ram_addr_s;
  assign busy     = (state_r != S_IDLE);
  assign done     = done_r;
  assign m_valid  = (count_r != 2'd0);
  assign m_data   = fifo_dat_r[rd_ptr_r];
  assign m_last   = m_valid & head_last_s;

  // Issue decision, address walk and FSM next state
  always_comb begin
    state_next_s = state_r;
    head_last_s  = fifo_last_r[rd_ptr_r];
    pop_s        = m_valid & m_ready;
    push_s       = inflight_r;
    accept_s     = (state_r == S_IDLE) & start & ~done_r;
    // A read issued now lands one cycle later; keep room for it even if nothing pops then.
    occ_s        = {1'b0, count_r} + {2'b00, inflight_r};
    lim_s        = 3'd2 + {2'b00, pop_s};
    issue_s      = (state_r == S_RUN) && (rem_r != {AW{1'b0}}) && (occ_s < lim_s);
    if (addr_r == AW'(DEPTH - 1)) begin
      addr_inc_s = {AW{1'b0}};
    end else begin
      addr_inc_s = addr_r + AW'(1);
    end
    if (issue_s) begin
      ram_addr_s = addr_r;
    end else begin
      ram_addr_s = hold_r;
    end
    done_next_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (length != {AW{1'b0}}) begin
            state_next_s = S_RUN;
          end else begin
            done_next_s = 1'b1;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (issue_s && (rem_r == AW'(1))) begin
          state_next_s = S_DRAIN;
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (pop_s && head_last_s) begin
          state_next_s = S_IDLE;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = S_DRAIN;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Control registers: FSM, address/remaining counters, read pipeline tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= S_IDLE;
      addr_r          <= {AW{1'b0}};
      hold_r          <= {AW{1'b0}};
      rem_r           <= {AW{1'b0}};
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      hold_r          <= ram_addr_s;
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s & (rem_r == AW'(1));
      done_r          <= done_next_s;
      if (accept_s) begin
        addr_r <= base_addr;
        rem_r  <= length;
      end else if (issue_s) begin
        addr_r <= addr_inc_s;
        rem_r  <= rem_r - AW'(1);
      end
    end
  end

  // Two-entry output buffer; the RAM word is captured unconditionally one cycle after issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_dat_r[i]  <= {DATA_WIDTH{1'b0}};
        fifo_last_r[i] <= 1'b0;
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_dat_r[wr_ptr_r]  <= ram_dout;
        fifo_last_r[wr_ptr_r] <= inflight_last_r;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized bench for bram_stream_reader: a queue-based burst model plus a RAM model,
// checked every cycle, with a few directed bursts pinned to literal values.
module tb_bram_stream_reader;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic          busy, done, ram_we, m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [DW-1:0] ram_di, m_data;
  logic [DW-1:0] ram_dout = '0;
  logic [AW-1:0] ram_addr;

  bram_stream_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_we(ram_we), .ram_di(ram_di), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [64];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            rmode = 0;
  int            pidx = 0;
  bit            pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // Reference model state
  logic [DW-1:0] exp_q [$];
  bit            exp_lq [$];
  bit            m_busy = 1'b0;
  bit            done_due = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  bit            prev_last;
  int            start_cyc = 0;
  int            done_cyc = -1;
  int            n_done = 0;
  int            beat_cyc [$];
  logic [DW-1:0] beat_dat [$];
  bit            beat_last [$];
  logic [AW-1:0] addr_log [int];

  task automatic check(input bit ok, input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] expv);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM: registered read, one cycle latency
  initial forever begin
    @(posedge clk);
    ram_dout <= mem[int'(ram_addr) % 64];
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: begin m_ready = pat[pidx % 7]; pidx++; end
      2: m_ready = 1'($urandom % 2);
      3: m_ready = 1'b0;
      default: m_ready = 1'b1;
    endcase
  end

  // Per-cycle compare against the burst model
  initial forever begin
    bit was_busy, done_nx;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      exp_lq.delete();
      m_busy     = 1'b0;
      done_due   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      addr_log[cyc] = ram_addr;
      was_busy = m_busy;
      done_nx  = 1'b0;
      check(done === done_due, "done", 32'(done), 32'(done_due));
      check(busy === m_busy, "busy", 32'(busy), 32'(m_busy));
      check(ram_we === 1'b0 && ram_di === '0, "ram_write_const", ram_di, 32'd0);
      if (done === 1'b1) begin
        done_cyc = cyc;
        n_done++;
      end
      if (prev_stall) begin
        check(m_valid === 1'b1 && m_data === prev_data && m_last === prev_last,
              "stall_stable", m_data, prev_data);
      end
      check(!(m_valid === 1'b1 && exp_q.size() == 0), "spurious_valid", 32'(m_valid), 32'd0);
      if (m_valid === 1'b1 && m_ready && exp_q.size() > 0) begin
        check(m_data === exp_q[0], "beat_data", m_data, exp_q[0]);
        check(m_last === exp_lq[0], "beat_last", 32'(m_last), 32'(exp_lq[0]));
        beat_cyc.push_back(cyc);
        beat_dat.push_back(m_data);
        beat_last.push_back(m_last);
        if (exp_lq[0]) begin
          done_nx = 1'b1;
          m_busy  = 1'b0;
        end
        void'(exp_q.pop_front());
        void'(exp_lq.pop_front());
      end
      if (start && !was_busy && !done_due) begin
        start_cyc = cyc;
        if (length == '0) begin
          done_nx = 1'b1;
        end else begin
          m_busy = 1'b1;
          for (int i = 0; i < int'(length); i++) begin
            exp_q.push_back(mem[(int'(base_addr) + i) % 64]);
            exp_lq.push_back(i == int'(length) - 1);
          end
        end
      end
      done_due   = done_nx;
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic pulse_start(input int b, input int l);
    @(posedge clk);
    #2;
    start     = 1'b1;
    base_addr = AW'(b);
    length    = AW'(l);
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_busy || done_due || exp_q.size() != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(k < budget, "wait_idle_timeout", 32'(k), 32'(budget));
  endtask

  task automatic clear_logs();
    beat_cyc.delete();
    beat_dat.delete();
    beat_last.delete();
    done_cyc = -1;
    n_done   = 0;
  endtask

  task automatic check_beats(input string nm, input logic [DW-1:0] lits [$]);
    check(beat_dat.size() == lits.size(), {nm, "_count"}, 32'(beat_dat.size()), 32'(lits.size()));
    for (int i = 0; i < lits.size() && i < beat_dat.size(); i++) begin
      check(beat_dat[i] === lits[i], {nm, "_data"}, beat_dat[i], lits[i]);
      check(beat_last[i] == (i == lits.size() - 1), {nm, "_last"}, 32'(beat_last[i]),
            32'(i == lits.size() - 1));
    end
  endtask

  initial begin
    logic [DW-1:0] lits [$];
    for (int i = 0; i < 64; i++) mem[i] = 32'h5A00_0000 + 32'(i);
    mem[0] = 32'hDDDDD;
    for (int i = 1; i <= 3; i++) mem[i] = 32'hCCCCC;
    for (int i = 4; i <= 6; i++) mem[i] = 32'hBBBBB;
    for (int i = 7; i <= 9; i++) mem[i] = 32'hAAAAA;
    for (int i = 61; i <= 63; i++) mem[i] = 32'hAAAAA;

    repeat (3) @(posedge clk);
    #2;
    check(m_valid === 1'b0 && m_last === 1'b0 && m_data === '0, "reset_stream", m_data, 32'd0);
    check(busy === 1'b0 && done === 1'b0, "reset_ctrl", {busy, done}, 32'd0);
    check(ram_addr === '0, "reset_ram_addr", 32'(ram_addr), 32'd0);
    rst = 1'b0;

    // Basic burst, cycle-exact
    rmode = 0;
    clear_logs();
    pulse_start(0, 4);
    wait_idle(50);
    lits = '{32'hDDDDD, 32'hCCCCC, 32'hCCCCC, 32'hCCCCC};
    check_beats("basic", lits);
    for (int i = 0; i < beat_cyc.size(); i++)
      check(beat_cyc[i] == start_cyc + 3 + i, "basic_beat_cycle", 32'(beat_cyc[i]),
            32'(start_cyc + 3 + i));
    check(done_cyc == start_cyc + 7, "basic_done_cycle", 32'(done_cyc), 32'(start_cyc + 7));
    check(addr_log[start_cyc + 1] === 13'd0, "basic_first_addr",
          32'(addr_log[start_cyc + 1]), 32'd0);

    // Wrap-around
    clear_logs();
    pulse_start(62, 4);
    wait_idle(50);
    lits = '{32'hAAAAA, 32'hAAAAA, 32'hDDDDD, 32'hCCCCC};
    check_beats("wrap", lits);
    check(addr_log[start_cyc + 1] === 13'd62, "wrap_addr0", 32'(addr_log[start_cyc + 1]), 32'd62);
    check(addr_log[start_cyc + 2] === 13'd63, "wrap_addr1", 32'(addr_log[start_cyc + 2]), 32'd63);
    check(addr_log[start_cyc + 3] === 13'd0, "wrap_addr2", 32'(addr_log[start_cyc + 3]), 32'd0);
    check(addr_log[start_cyc + 4] === 13'd1, "wrap_addr3", 32'(addr_log[start_cyc + 4]), 32'd1);

    // Backpressure pattern
    clear_logs();
    pidx  = 0;
    rmode = 1;
    pulse_start(4, 6);
    wait_idle(100);
    lits = '{32'hBBBBB, 32'hBBBBB, 32'hBBBBB, 32'hAAAAA, 32'hAAAAA, 32'hAAAAA};
    check_beats("bp", lits);

    // Zero length
    rmode = 0;
    clear_logs();
    pulse_start(0, 0);
    wait_idle(20);
    check(done_cyc == start_cyc + 1, "len0_done_cycle", 32'(done_cyc), 32'(start_cyc + 1));
    check(beat_dat.size() == 0, "len0_no_beats", 32'(beat_dat.size()), 32'd0);

    // Start during a burst is ignored
    clear_logs();
    pulse_start(0, 2);
    pulse_start(9, 3);
    wait_idle(50);
    lits = '{32'hDDDDD, 32'hCCCCC};
    check_beats("restart", lits);
    check(n_done == 1, "restart_one_done", 32'(n_done), 32'd1);

    // Reset mid-burst with the buffer full
    rmode = 3;
    pulse_start(0, 20);
    repeat (6) @(posedge clk);
    check(m_valid === 1'b1 && busy === 1'b1, "pre_reset_buffered", {m_valid, busy}, 32'd3);
    #1;
    rst = 1'b1;
    #1;
    check(m_valid === 1'b0 && busy === 1'b0 && done === 1'b0, "reset_mid_burst",
          {m_valid, busy, done}, 32'd0);
    @(posedge clk);
    #2;
    rst   = 1'b0;
    rmode = 0;
    clear_logs();
    pulse_start(7, 1);
    wait_idle(30);
    lits = '{32'hAAAAA};
    check_beats("post_reset", lits);

    // Randomized bursts over random RAM contents
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int t = 0; t < 30; t++) begin
      rmode = $urandom_range(0, 2);
      pulse_start($urandom_range(0, 63), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 140));
      if ($urandom_range(0, 1) == 1) pulse_start($urandom_range(0, 63), $urandom_range(0, 8));
      wait_idle(2000);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read sequencer that sits directly upstream of the single-port 64-entry block RAM in the PS-PL shared channel. On a start command it walks a contiguous, wrap-around address range in the RAM and streams the words out on a valid/ready interface, with end-of-burst marking. It absorbs the RAM's fixed 1-cycle read latency with a 2-entry output buffer, so backpressure never loses or duplicates data.

## Interface
- ADDR_WIDTH, 12, RAM address parameter; the RAM address port is ADDR_WIDTH+1 bits wide.
- DATA_WIDTH, 32, word width.
- DEPTH, 64, physical RAM entries; addresses wrap modulo DEPTH.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle command strobe; honoured only when idle.
- base_addr  in  ADDR_WIDTH+1  first word address, sampled with start; must be < DEPTH.
- length  in  ADDR_WIDTH+1  word count, sampled with start; 0 is legal.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- ram_we  out  1  RAM write enable, constant 0.
- ram_di  out  DATA_WIDTH  RAM write data, constant 0.
- ram_addr  out  ADDR_WIDTH+1  RAM address.
- ram_dout  in  DATA_WIDTH  RAM read data; registered in the RAM, valid the cycle after ram_addr.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final beat of the burst.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE: start=1 with length≠0 -> RUN; base_addr and length are latched. start=1 with length=0 -> done pulses the next cycle and the state stays IDLE.
  - RUN: issues reads. After the last address is issued -> DRAIN.
  - DRAIN: waits for the last beat to be accepted -> IDLE, with done pulsed.
- start in RUN or DRAIN is ignored.
- Issue rule: a read is issued in a cycle when (fifo_count + inflight − pop) < 2.
  - inflight is 1 if a read was issued the previous cycle.
  - pop = m_valid & m_ready.
- An issued read captures ram_dout into the FIFO exactly one cycle later, unconditionally.
- On issue, the read address advances by +1. DEPTH−1 wraps to 0.
- A remaining-word counter decrements on each issue. It marks the entry for the final word so that m_last=1 with that beat only.
- FIFO: 2 entries. m_data/m_valid come from the head. Data and m_last stay stable while m_valid=1 and m_ready=0.
- Simultaneous push and pop is supported; FIFO occupancy is unchanged in that case.
- ram_addr holds its last value when no read is issued. The RAM output it produces is ignored.
- busy=1 from the cycle after an accepted start until the cycle done=1. busy is 0 in the done cycle.
- length > DEPTH is legal: the burst re-reads wrapped addresses.

## Timing
- Reset (async, immediate) sets:
  - m_valid=0, m_last=0, m_data=0
  - busy=0, done=0
  - ram_addr=0, ram_we=0, ram_di=0
  - state IDLE, FIFO empty, inflight=0
- Reset mid-burst discards in-flight and buffered words. No done pulse is generated.
- With start sampled in cycle N:
  - ram_addr=base_addr in cycle N+1
  - ram_dout valid in cycle N+2, captured at the end of N+2
  - m_valid=1 in cycle N+3
- With m_ready held at 1: one beat per cycle, no bubbles, L beats in cycles N+3 … N+2+L.
- done pulses in the cycle after the m_last handshake.
- Earliest next accepted start is the cycle after done.

## Test plan
Use the RAM's initial contents: [0]=DDDDD, [1..3]=CCCCC, [4..6]=BBBBB, [7..9]=AAAAA, [61..63]=AAAAA.
- base=0, len=4, m_ready=1 -> DDDDD, CCCCC, CCCCC, CCCCC in consecutive cycles N+3..N+6. m_last on the 4th beat; done at N+7; busy low at N+7.
- Wrap: base=62, len=4 -> AAAAA, AAAAA, DDDDD, CCCCC; ram_addr sequence 62, 63, 0, 1.
- Backpressure: base=4, len=6, m_ready pattern 1,0,0,1,1,0,1… -> exactly BBBBB×3 then AAAAA×3. No drop or duplicate; m_data held stable during stalls; ram_addr never more than 2 ahead of accepted beats.
- len=0 -> done=1 at N+1; m_valid never rises; busy stays 0.
- start pulsed again during a burst (base=0, len=2) -> ignored; only the original burst's beats appear and there is one done.
- rst asserted mid-burst with 2 words buffered -> m_valid, busy and done drop immediately. A fresh start (base=7, len=1) then yields a single AAAAA beat with m_last=1.
